// File: rtl/spi_rgb_pkg.sv
// Shared constants and FSM encoding for the RGB LED driver SPI frame transmitter.
package spi_rgb_pkg;

  localparam int unsigned FRAME_BITS   = 264;
  localparam int unsigned PAYLOAD_BITS = 256;
  localparam int unsigned BANK_BITS    = 8;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StShift,
    StTrail,
    StGap
  } state_e;

  // Wire order of a frame: bank header first, payload after, both MSB first.
  function automatic frame_t pack_frame(input logic [BANK_BITS-1:0]    bank,
                                        input logic [PAYLOAD_BITS-1:0] data);
    return {bank, data};
  endfunction

endpackage

// File: rtl/spi_rgb_frame_tx_if.sv
// Host-mux write port: one-cycle DATA_WRITE_COPY strobe qualifying BANK and DATA.
interface spi_rgb_frame_tx_if;
  import spi_rgb_pkg::*;

  logic [PAYLOAD_BITS-1:0] DATA;
  logic [BANK_BITS-1:0]    BANK;
  logic                    DATA_WRITE_COPY;

  modport master (
    output DATA,
    output BANK,
    output DATA_WRITE_COPY
  );

  modport slave (
    input DATA,
    input BANK,
    input DATA_WRITE_COPY
  );

endinterface

// File: rtl/spi_rgb_clkdiv.sv
// Programmable half-period tick generator for SPI masters. While enabled it runs an
// internal low/high phase of half_period_i cycles each, starting low, and strikes rise_o
// (end of a low phase) or fall_o (end of a high phase) on the last cycle of each phase.
module spi_rgb_clkdiv (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       en_i,
  input  logic [7:0] half_period_i,
  output logic       rise_o,
  output logic       fall_o
);

  logic [7:0] cnt_q;
  logic       phase_q;
  logic       wrap;

  assign wrap   = en_i && (cnt_q == half_period_i - 8'd1);
  assign rise_o = wrap && !phase_q;
  assign fall_o = wrap && phase_q;

  // Phase counter; disabling restarts the next run from the start of a low phase.
  always_ff @(posedge CLK) begin
    if (RESET || !en_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_rgb_frame_tx.sv
// Serialises host-mux writes as SPI mode-0 frames (8-bit bank header + 256-bit payload)
// towards the RGB LED driver, with a one-deep pending buffer in front of the shifter.
module spi_rgb_frame_tx
  import spi_rgb_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,  // SCK half-period in CLK cycles, 1..255
  parameter int unsigned CS_GAP  = 8   // minimum CS_N high time between frames, 1..255
) (
  input  logic               CLK,
  input  logic               RESET,
  spi_rgb_frame_tx_if.slave  host,
  output logic               SPI_SCK,
  output logic               SPI_MOSI,
  output logic               SPI_CS_N,
  output logic               BUSY,
  output logic               BANK_DONE,
  output logic               OVERRUN
);

  state_e      state_q;
  frame_t      pend_q;
  logic        pend_valid_q;
  frame_t      shreg_q;
  logic [8:0]  bit_cnt_q;
  logic [7:0]  gap_cnt_q;
  logic        sck_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic        busy_q;
  logic        done_q;
  logic        ovr_q;

  logic        load;
  logic        div_en;
  logic        div_rise;
  logic        div_fall;

  // The FSM takes the pending entry in the same cycle it sees it in idle.
  assign load   = (state_q == StIdle) && pend_valid_q;
  // The divider runs for exactly the CS-low window; its phases line up with
  // lead, each bit's high/low half and the trailing hold.
  assign div_en = (state_q == StLead) || (state_q == StShift) || (state_q == StTrail);

  spi_rgb_clkdiv u_clkdiv (
    .CLK           (CLK),
    .RESET         (RESET),
    .en_i          (div_en),
    .half_period_i (8'(CLK_DIV)),
    .rise_o        (div_rise),
    .fall_o        (div_fall)
  );

  // Pending buffer: latest write wins; overwrite is flagged unless the entry leaves this cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      ovr_q <= host.DATA_WRITE_COPY && pend_valid_q && !load;
      if (host.DATA_WRITE_COPY) begin
        pend_q       <= pack_frame(host.BANK, host.DATA);
        pend_valid_q <= 1'b1;
      end else if (load) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // Frame FSM with registered SPI pins and status.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shreg_q   <= pend_q;
            mosi_q    <= pend_q[FRAME_BITS-1];
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= StLead;
          end
        end
        StLead: begin
          if (div_rise) begin
            sck_q   <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (div_rise) begin
            sck_q <= 1'b1;
          end else if (div_fall) begin
            sck_q <= 1'b0;
            // MOSI holds the last bit through the trailing phase.
            if (bit_cnt_q == 9'(FRAME_BITS - 1)) begin
              state_q <= StTrail;
            end else begin
              bit_cnt_q <= bit_cnt_q + 9'd1;
              shreg_q   <= {shreg_q[FRAME_BITS-2:0], 1'b0};
              mosi_q    <= shreg_q[FRAME_BITS-2];
            end
          end
        end
        StTrail: begin
          if (div_rise) begin
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == 8'(CS_GAP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign SPI_SCK   = sck_q;
  assign SPI_MOSI  = mosi_q;
  assign SPI_CS_N  = cs_n_q;
  assign BUSY      = busy_q;
  assign BANK_DONE = done_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: doc/spi_rgb_frame_tx.md
# spi_rgb_frame_tx

Consumer end of the host-mux write interface: accepts the DATA / BANK / DATA_WRITE_COPY strobe stream produced by the host multiplexer and serialises each accepted write as one SPI frame (8-bit bank header followed by the 256-bit payload) to the RGB LED driver. It sits between the host multiplexer and the board-level SPI pins. A one-deep pending buffer decouples host writes from the SPI transfer.

## Interface
- CLK_DIV, 4: SCK half-period in CLK cycles; legal range 1..255.
- CS_GAP, 8: minimum CLK cycles SPI_CS_N stays high between frames; legal range 1..255.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA  in  256  payload; sampled only in a cycle where DATA_WRITE_COPY=1.
- BANK  in  8  target bank; sampled with DATA.
- DATA_WRITE_COPY  in  1  single-cycle write strobe from the host multiplexer.
- SPI_SCK  out  1  SPI clock, mode 0 (idle low).
- SPI_MOSI  out  1  serial data, MSB first.
- SPI_CS_N  out  1  active-low frame select.
- BUSY  out  1  high from frame load until end of CS gap.
- BANK_DONE  out  1  one-cycle pulse when a frame completes.
- OVERRUN  out  1  one-cycle pulse when a pending write is overwritten.

## Operation
- Reset values: SPI_SCK=0, SPI_MOSI=0, SPI_CS_N=1, BUSY=0, BANK_DONE=0, OVERRUN=0; pending buffer invalid; FSM IDLE.
- Capture: in any cycle with DATA_WRITE_COPY=1, {BANK, DATA} is written into the pending buffer and pending_valid is set. The strobe is a level sample; a strobe held high for N cycles counts as N writes.
- Overwrite: a strobe arriving while pending_valid=1 and the pending entry is not being loaded in that cycle replaces the entry (latest wins) and pulses OVERRUN for one cycle.
- FSM states: IDLE, LEAD, SHIFT, TRAIL, GAP.
- IDLE: if pending_valid, then load the 264-bit shift register with {BANK, DATA}, clear pending_valid, drive SPI_CS_N=0 and SPI_MOSI=bit 263, set BUSY, and go to LEAD.
- LEAD: SCK stays low for CLK_DIV cycles, then go to SHIFT.
- SHIFT: SCK is high for CLK_DIV cycles and then low for CLK_DIV cycles, once per bit. MOSI changes only on SCK falling edges. After the 264th high phase, SCK returns low and the FSM goes to TRAIL.
- TRAIL: CLK_DIV cycles with CS low and SCK low, then SPI_CS_N=1, MOSI=0, BANK_DONE pulse, and go to GAP.
- GAP: CS_GAP cycles, then clear BUSY and go to IDLE.
- Simultaneous load and strobe: the FSM loads the old pending entry; the new write enters the buffer; pending_valid stays 1; no OVERRUN.
- RESET asserted mid-frame: all outputs take their reset values at the next edge. The frame is abandoned, the pending entry is discarded, and there is no BANK_DONE pulse.

## Timing
- Strobe at edge n: pending_valid=1 after n. With the FSM in IDLE, CS_N falls after edge n+1.
- First SCK rising edge comes CLK_DIV cycles after CS_N falls.
- CS_N low duration per frame: (2·264+1)·CLK_DIV cycles, which is 2116 for CLK_DIV=4.
- Frame-to-frame period with a continuously valid pending entry: CS low duration + CS_GAP + 1 (IDLE load) cycles.
- MOSI is stable for CLK_DIV cycles before and after each SCK rising edge.
- Counter widths: bit counter 9 bits (0..263), divider counter 8 bits, gap counter 8 bits. No wrap is permitted; each counter resets to 0 on state entry.

## Structure
- Shared package spi_rgb_pkg: FRAME_BITS=264, PAYLOAD_BITS=256, BANK_BITS=8, and the FSM state encoding (shared with the bench monitor).
- One sub-module, spi_rgb_clkdiv: a programmable half-period tick generator with an enable input. It emits rise/fall strike pulses for SCK and is reused by other SPI masters.
- Pending buffer, shift register and FSM are in the top module.

## Test plan
- Single write: BANK=0x05, DATA=256'h00…0A5, CLK_DIV=4 -> CS_N low for 2116 cycles; the first 8 MOSI bits sampled on SCK rise are 00000101, the last 8 are 10100101; one BANK_DONE; OVERRUN never pulses.
- Back-to-back: a second strobe (BANK=0x06) arrives mid-frame -> second frame starts CS_GAP+1 cycles after the first CS_N rise with header 0x06; no OVERRUN.
- Overrun: three strobes (BANK 1, 2, 3) during one frame -> one OVERRUN pulse (at the third strobe); the next frame carries BANK=3; two BANK_DONE pulses total.
- Simultaneous: a strobe lands exactly on the IDLE load cycle -> the old entry is transmitted, the new one follows in the next frame, and OVERRUN=0.
- Reset mid-frame: RESET is asserted at bit 100 -> next edge CS_N=1, SCK=0, MOSI=0, BUSY=0; no BANK_DONE; a strobe after reset release transmits normally.
- CLK_DIV=1 corner: one write -> CS low for 529 cycles, SCK period 2 cycles, and all 264 bits are correct.
